// File: rtl/hdmi_timing_pkg.sv
// hdmi_timing_pkg
// Shared constants for the HDMI frame scheduler: period (mode) codes, control
// word constants for the preambles, period lengths and the island state type.
// The helpers give the end of an island and the latest cx an island may reach.
// No ports (package).
package hdmi_timing_pkg;

  // Per-cycle HDMI period codes presented on the mode output
  localparam logic [2:0] MODE_CTRL         = 3'd0;
  localparam logic [2:0] MODE_VIDEO        = 3'd1;
  localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd2;
  localparam logic [2:0] MODE_ISLAND_DATA  = 3'd3;
  localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;

  // {CTL3,CTL2,CTL1,CTL0} during control periods
  localparam logic [3:0] CTRL_IDLE       = 4'b0000;
  localparam logic [3:0] CTRL_VIDEO_PRE  = 4'b0001;
  localparam logic [3:0] CTRL_ISLAND_PRE = 4'b0101;

  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;
  localparam int CTRL_MARGIN  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DI_PRE,
    ST_DI_LEAD,
    ST_DI_PKT,
    ST_DI_TRAIL
  } island_state_t;

  // First cx after an island that starts at start_x and carries n packets
  function automatic int island_end(input int start_x, input int packets);
    return start_x + PREAMBLE_LEN + 2 * GUARD_LEN + PACKET_LEN * packets;
  endfunction

  // Islands must end here or earlier so a few control cycles separate them
  // from the video preamble that every active line may carry.
  function automatic int island_limit(input int h_blank);
    return h_blank - CTRL_MARGIN - PREAMBLE_LEN - GUARD_LEN;
  endfunction

endpackage

// File: rtl/hdmi_island_scheduler.sv
// hdmi_island_scheduler
// Data-island FSM: starts an island at cx=ISLAND_START_X when a packet is
// pending and fits, then chains 32-cycle packet slots while packets keep
// coming, the packet ceiling is not reached and the next slot still fits.
// Outputs are combinational for the current cycle; the top registers them.
// Ports:
//   clk_pixel, reset     pixel clock, synchronous active-high reset
//   cx                   current horizontal counter
//   packet_pending       producer holds at least one packet
//   island_pre           island preamble cycle
//   island_guard         island leading/trailing guard cycle
//   island_data          packet slot cycle
//   packet_start         first cycle of a packet slot
//   slot_cycle           index 0..31 within the packet slot (0 outside)
module hdmi_island_scheduler
  import hdmi_timing_pkg::*;
#(
  parameter int ISLAND_START_X = 4,
  parameter int H_BLANK        = 160,
  parameter int MAX_PACKETS    = 18,
  parameter bit DVI_OUTPUT     = 1'b0,
  parameter int BIT_WIDTH      = 9
) (
  input  logic               clk_pixel,
  input  logic               reset,
  input  logic [BIT_WIDTH:0] cx,
  input  logic               packet_pending,
  output logic               island_pre,
  output logic               island_guard,
  output logic               island_data,
  output logic               packet_start,
  output logic [4:0]         slot_cycle
);

  localparam logic [BIT_WIDTH:0] START_X   = (BIT_WIDTH + 1)'(ISLAND_START_X);
  localparam int                 FIT_LIMIT = island_limit(H_BLANK);

  island_state_t state_reg, state_next, cur_state;
  logic [4:0]    cnt_reg, cnt_next, cur_cnt;
  logic [7:0]    pkts_reg, pkts_next, cur_pkts;
  logic          start_now;
  logic          more_fits;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      pkts_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pkts_reg  <= pkts_next;
    end
  end

  always_comb begin
    // The cycle at ISLAND_START_X is already the first preamble cycle, so the
    // start decision folds into the effective state of this very cycle.
    start_now = !DVI_OUTPUT && (state_reg == ST_IDLE) && (cx == START_X) &&
                packet_pending && (island_end(ISLAND_START_X, 1) <= FIT_LIMIT);
    cur_state = state_reg;
    cur_cnt   = cnt_reg;
    cur_pkts  = pkts_reg;
    if (start_now) begin
      cur_state = ST_DI_PRE;
      cur_cnt   = '0;
      cur_pkts  = '0;
    end

    more_fits    = island_end(ISLAND_START_X, int'(cur_pkts) + 1) <= FIT_LIMIT;
    state_next   = cur_state;
    cnt_next     = cur_cnt + 5'd1;
    pkts_next    = cur_pkts;
    island_pre   = 1'b0;
    island_guard = 1'b0;
    island_data  = 1'b0;
    packet_start = 1'b0;
    slot_cycle   = '0;

    case (cur_state)
      ST_IDLE: begin
        cnt_next = '0;
      end
      ST_DI_PRE: begin
        island_pre = 1'b1;
        if (cur_cnt == 5'(PREAMBLE_LEN - 1)) begin
          state_next = ST_DI_LEAD;
          cnt_next   = '0;
        end
      end
      ST_DI_LEAD: begin
        island_guard = 1'b1;
        if (cur_cnt == 5'(GUARD_LEN - 1)) begin
          state_next = ST_DI_PKT;
          cnt_next   = '0;
          pkts_next  = cur_pkts + 8'd1;
        end
      end
      ST_DI_PKT: begin
        island_data  = 1'b1;
        slot_cycle   = cur_cnt;
        packet_start = (cur_cnt == 5'd0);
        // pending is only looked at on the last slot cycle: a drop mid-slot
        // never shortens the packet in flight.
        if (cur_cnt == 5'(PACKET_LEN - 1)) begin
          cnt_next = '0;
          if (packet_pending && (int'(cur_pkts) < MAX_PACKETS) && more_fits) begin
            pkts_next = cur_pkts + 8'd1;
          end else begin
            state_next = ST_DI_TRAIL;
          end
        end
      end
      ST_DI_TRAIL: begin
        island_guard = 1'b1;
        if (cur_cnt == 5'(GUARD_LEN - 1)) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hdmi_frame_scheduler.sv
// hdmi_frame_scheduler
// Pixel-clock raster timing and HDMI period scheduler. Blanking precedes the
// active region on both axes. cx/cy are the counter registers; every other
// output is registered from a decode of cx/cy/island FSM and so lags cx by one.
// Ports:
//   clk_pixel, reset   pixel clock, synchronous active-high reset
//   packet_pending     producer holds at least one packet
//   packet_accept      one-cycle pulse on the first cycle of a packet slot
//   packet_cycle       index 0..31 within the current packet slot
//   cx, cy             horizontal / vertical counters
//   hsync, vsync       sync outputs, active level set by *_POL
//   mode               0 control, 1 video, 2 video guard, 3 island data, 4 island guard
//   ctrl               {CTL3,CTL2,CTL1,CTL0}
//   frame_start        pulse decoded from cx=0, cy=0
module hdmi_frame_scheduler
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE       = 640,
  parameter int H_FRONT        = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BACK         = 48,
  parameter int V_ACTIVE       = 480,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33,
  parameter bit HSYNC_POL      = 1'b0,
  parameter bit VSYNC_POL      = 1'b0,
  parameter bit DVI_OUTPUT     = 1'b0,
  parameter int ISLAND_START_X = 4,
  parameter int MAX_PACKETS    = 18,
  parameter int BIT_WIDTH      = 9,
  parameter int BIT_HEIGHT     = 9
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic                packet_pending,
  output logic                packet_accept,
  output logic [4:0]          packet_cycle,
  output logic [BIT_WIDTH:0]  cx,
  output logic [BIT_HEIGHT:0] cy,
  output logic                hsync,
  output logic                vsync,
  output logic [2:0]          mode,
  output logic [3:0]          ctrl,
  output logic                frame_start
);

  localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
  localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
  localparam int H_TOTAL = H_BLANK + H_ACTIVE;
  localparam int V_TOTAL = V_BLANK + V_ACTIVE;

  localparam logic [BIT_WIDTH:0]  CX_ONE    = (BIT_WIDTH + 1)'(1);
  localparam logic [BIT_WIDTH:0]  CX_LAST   = (BIT_WIDTH + 1)'(H_TOTAL - 1);
  localparam logic [BIT_WIDTH:0]  HS_START  = (BIT_WIDTH + 1)'(H_FRONT);
  localparam logic [BIT_WIDTH:0]  HS_END    = (BIT_WIDTH + 1)'(H_FRONT + H_SYNC);
  localparam logic [BIT_WIDTH:0]  CX_ACTIVE = (BIT_WIDTH + 1)'(H_BLANK);
  localparam logic [BIT_WIDTH:0]  CX_GUARD  = (BIT_WIDTH + 1)'(H_BLANK - GUARD_LEN);
  localparam logic [BIT_WIDTH:0]  CX_VPRE   = (BIT_WIDTH + 1)'(H_BLANK - GUARD_LEN - PREAMBLE_LEN);
  localparam logic [BIT_HEIGHT:0] CY_ONE    = (BIT_HEIGHT + 1)'(1);
  localparam logic [BIT_HEIGHT:0] CY_LAST   = (BIT_HEIGHT + 1)'(V_TOTAL - 1);
  localparam logic [BIT_HEIGHT:0] VS_START  = (BIT_HEIGHT + 1)'(V_FRONT);
  localparam logic [BIT_HEIGHT:0] VS_END    = (BIT_HEIGHT + 1)'(V_FRONT + V_SYNC);
  localparam logic [BIT_HEIGHT:0] CY_ACTIVE = (BIT_HEIGHT + 1)'(V_BLANK);

  // A single-packet island must fit in horizontal blanking on every line.
  generate
    if (!DVI_OUTPUT && (island_end(ISLAND_START_X, 1) > island_limit(H_BLANK))) begin : g_bad_blanking
      $error("hdmi_frame_scheduler: H_BLANK too small for a data island");
    end
  endgenerate

  logic [BIT_WIDTH:0]  cx_reg;
  logic [BIT_HEIGHT:0] cy_reg;
  logic                hsync_reg, vsync_reg, frame_start_reg, accept_reg;
  logic [2:0]          mode_reg, mode_next;
  logic [3:0]          ctrl_reg, ctrl_next;
  logic [4:0]          packet_cycle_reg;
  logic                hsync_next, vsync_next, active_line;
  logic                island_pre, island_guard, island_data, packet_start;
  logic [4:0]          slot_cycle;

  hdmi_island_scheduler #(
    .ISLAND_START_X (ISLAND_START_X),
    .H_BLANK        (H_BLANK),
    .MAX_PACKETS    (MAX_PACKETS),
    .DVI_OUTPUT     (DVI_OUTPUT),
    .BIT_WIDTH      (BIT_WIDTH)
  ) u_island (
    .clk_pixel      (clk_pixel),
    .reset          (reset),
    .cx             (cx_reg),
    .packet_pending (packet_pending),
    .island_pre     (island_pre),
    .island_guard   (island_guard),
    .island_data    (island_data),
    .packet_start   (packet_start),
    .slot_cycle     (slot_cycle)
  );

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cx_reg <= '0;
      cy_reg <= '0;
    end else if (cx_reg == CX_LAST) begin
      cx_reg <= '0;
      cy_reg <= (cy_reg == CY_LAST) ? '0 : cy_reg + CY_ONE;
    end else begin
      cx_reg <= cx_reg + CX_ONE;
    end
  end

  always_comb begin
    active_line = (cy_reg >= CY_ACTIVE);
    mode_next   = MODE_CTRL;
    ctrl_next   = CTRL_IDLE;
    if (island_pre)   ctrl_next = CTRL_ISLAND_PRE;
    if (island_guard) mode_next = MODE_ISLAND_GUARD;
    if (island_data)  mode_next = MODE_ISLAND_DATA;
    // The fit rule keeps islands clear of the video lead-in, so no overlap.
    if (active_line) begin
      if (cx_reg >= CX_ACTIVE)                     mode_next = MODE_VIDEO;
      else if (!DVI_OUTPUT && cx_reg >= CX_GUARD)  mode_next = MODE_VIDEO_GUARD;
      else if (!DVI_OUTPUT && cx_reg >= CX_VPRE)   ctrl_next = CTRL_VIDEO_PRE;
    end
    hsync_next = ((cx_reg >= HS_START) && (cx_reg < HS_END)) ? HSYNC_POL : !HSYNC_POL;
    vsync_next = ((cy_reg >= VS_START) && (cy_reg < VS_END)) ? VSYNC_POL : !VSYNC_POL;
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      hsync_reg        <= !HSYNC_POL;
      vsync_reg        <= !VSYNC_POL;
      mode_reg         <= MODE_CTRL;
      ctrl_reg         <= CTRL_IDLE;
      frame_start_reg  <= 1'b0;
      accept_reg       <= 1'b0;
      packet_cycle_reg <= '0;
    end else begin
      hsync_reg        <= hsync_next;
      vsync_reg        <= vsync_next;
      mode_reg         <= mode_next;
      ctrl_reg         <= ctrl_next;
      frame_start_reg  <= (cx_reg == '0) && (cy_reg == '0);
      accept_reg       <= packet_start;
      packet_cycle_reg <= slot_cycle;
    end
  end

  assign cx            = cx_reg;
  assign cy            = cy_reg;
  assign hsync         = hsync_reg;
  assign vsync         = vsync_reg;
  assign mode          = mode_reg;
  assign ctrl          = ctrl_reg;
  assign frame_start   = frame_start_reg;
  assign packet_accept = accept_reg;
  assign packet_cycle  = packet_cycle_reg;

endmodule
